xy_input_conditioner: RTL and testbench



---
 rtl/xy_input_conditioner.sv | 92 +++++++++
 tb/tb_xy_input_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/xy_input_conditioner.sv
// xy_input_conditioner
//   Cleans up two raw, asynchronous, bouncy switch inputs (x, y) and turns them
//   into a registered 2-bit input bus m = {x, y} for the downstream Mealy
//   controller. Each channel has a 2-flop synchronizer and then a
//   stability-count debouncer. One-cycle rise/fall/change strobes let the
//   controller step once for each accepted input change.
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   x_raw     in   raw switch x (asynchronous, may bounce)
//   y_raw     in   raw switch y (asynchronous, may bounce)
//   m         out  [1:0] debounced level {x, y}
//   m_rise    out  [1:0] one-cycle pulse per bit on a debounced 0->1 flip
//   m_fall    out  [1:0] one-cycle pulse per bit on a debounced 1->0 flip
//   m_change  out  one-cycle pulse, OR of all m_rise/m_fall bits
//   stable    out  both debounce counters idle (no change pending)
module xy_input_conditioner #(
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       x_raw,
  input  logic       y_raw,
  output logic [1:0] m,
  output logic [1:0] m_rise,
  output logic [1:0] m_fall,
  output logic       m_change,
  output logic       stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [1:0]            s1_q;
  logic [1:0]            s2_q;
  logic [1:0]            m_q;
  logic [1:0]            m_d;
  logic [1:0]            rise_q;
  logic [1:0]            fall_q;
  logic                  change_q;
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;

  // Debounce: the counter runs only while the synchronized level disagrees
  // with the accepted level. Any agreement (a bounce back) clears it, so a
  // flip needs DEBOUNCE_CNT consecutive mismatching samples. The counter is
  // cleared on the flip itself, so it never wraps.
  always_comb begin
    m_d   = m_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == m_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        m_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      m_q      <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      s1_q     <= {x_raw, y_raw};
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      // Strobes are registered from the same next-state as m, so they are
      // high in exactly the cycle in which the new level first appears.
      rise_q   <= m_d & ~m_q;
      fall_q   <= ~m_d & m_q;
      change_q <= |(m_d ^ m_q);
    end
  end

  assign m        = m_q;
  assign m_rise   = rise_q;
  assign m_fall   = fall_q;
  assign m_change = change_q;
  assign stable   = (cnt_q[1] == '0) && (cnt_q[0] == '0);

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Directed bench for xy_input_conditioner (DEBOUNCE_CNT = 4).
// The observed word packs {m, m_rise, m_fall, m_change, stable}.
// "Edge 0" is the first rising edge that samples a new raw level.
module tb_xy_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       x_raw = 1'b0;
  logic       y_raw = 1'b0;
  logic [1:0] m;
  logic [1:0] m_rise;
  logic [1:0] m_fall;
  logic       m_change;
  logic       stable;

  int n_vec  = 0;
  int n_miss = 0;

  xy_input_conditioner #(.DEBOUNCE_CNT(4), .CNT_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .x_raw    (x_raw),
    .y_raw    (y_raw),
    .m        (m),
    .m_rise   (m_rise),
    .m_fall   (m_fall),
    .m_change (m_change),
    .stable   (stable)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ev(input logic [1:0] em, input logic [1:0] er,
                                    input logic [1:0] ef, input logic ec,
                                    input logic es);
    return {em, er, ef, ec, es};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got m/r/f/c/s=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] obs_word();
    return {m, m_rise, m_fall, m_change, stable};
  endfunction

  // Apply a new held raw level and check edges 0..6 of the qualification.
  task automatic qualify(input string tag, input logic nx, input logic ny,
                         input logic [1:0] mo, input logic [1:0] mn,
                         input logic [1:0] er, input logic [1:0] ef);
    logic [7:0] e;
    x_raw = nx;
    y_raw = ny;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k < 2)       e = ev(mo, 2'b00, 2'b00, 1'b0, 1'b1);
      else if (k < 5)  e = ev(mo, 2'b00, 2'b00, 1'b0, 1'b0);
      else if (k == 5) e = ev(mn, er, ef, 1'b1, 1'b1);
      else             e = ev(mn, 2'b00, 2'b00, 1'b0, 1'b1);
      chk($sformatf("%s_e%0d", tag, k), obs_word(), e);
    end
  endtask

  initial begin
    logic [7:0] e;

    // 1: reset state, then idle
    reset = 1'b1;
    step();
    step();
    chk("reset", obs_word(), ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("idle_%0d", k), obs_word(), ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    end

    // 3: y glitch sampled high at edges 0..2 only; counter reaches 3 then clears
    y_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 2) y_raw = 1'b0;
      if (k >= 2 && k <= 4) e = ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      else                  e = ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      chk($sformatf("glitch_e%0d", k), obs_word(), e);
    end

    // 2: x rises alone
    qualify("x_rise", 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00);

    // 5: x falls while y rises on the same edge
    qualify("swap", 1'b0, 1'b1, 2'b10, 2'b01, 2'b01, 2'b10);

    // y falls alone back to 00
    qualify("y_fall", 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01);

    // 4: both rise on the same edge
    qualify("both_rise", 1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 2'b00);

    // 6: reset mid-count, then full re-qualification
    reset = 1'b1;
    x_raw = 1'b0;
    y_raw = 1'b0;
    step();
    step();
    chk("reset2", obs_word(), ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step();
    x_raw = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 3) reset = 1'b1;
      if (k == 4) reset = 1'b0;
      step();
      if (k == 2)                   e = ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      else if (k >= 6 && k <= 8)    e = ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
      else if (k == 9)              e = ev(2'b10, 2'b10, 2'b00, 1'b1, 1'b1);
      else if (k == 10)             e = ev(2'b10, 2'b00, 2'b00, 1'b0, 1'b1);
      else                          e = ev(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      chk($sformatf("rst_mid_e%0d", k), obs_word(), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
